// File: rtl/botones_pkg.sv
// Shared encodings for the pet's button front-end: per-button state and button indices.
package botones_pkg;

  typedef enum logic [1:0] {
    SUELTO     = 2'd0,
    PRESIONADO = 2'd1,
    SOSTENIDO  = 2'd2
  } estado_t;

  localparam int unsigned N_BTN = 5;
  localparam int unsigned N_ACC = 3;

  // Action buttons come first; a lower index wins a same-cycle collision.
  localparam int unsigned IDX_COMER     = 0;
  localparam int unsigned IDX_JUGAR     = 1;
  localparam int unsigned IDX_DESCANSAR = 2;
  localparam int unsigned IDX_TEST      = 3;
  localparam int unsigned IDX_ACELERAR  = 4;

endpackage

// File: rtl/botones_entrada_antirrebote.sv
// One button lane: polarity normalise, 2-flop synchroniser, debounce counter,
// arming after release, and registered rise/fall strobes of the debounced level.
module antirrebote
  import botones_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic sube,
  output logic baja
);

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pulsado_c;
  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             armado_q, armado_d;
  logic             sube_q, sube_d;
  logic             baja_q, baja_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pulsado_c = btn_raw ^ BTN_ACTIVE_LOW;

  // Debounce and arming; strobes only leave an armed lane.
  always_comb begin
    deb_d    = deb_q;
    cnt_d    = '0;
    sube_d   = 1'b0;
    baja_d   = 1'b0;
    armado_d = armado_q | (~deb_q & ~sync2_q);
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_FIN) begin
        deb_d  = sync2_q;
        sube_d = armado_q & sync2_q;
        baja_d = armado_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser resets to "pressed" so a button held through reset cannot arm.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      deb_q    <= 1'b0;
      cnt_q    <= '0;
      armado_q <= 1'b0;
      sube_q   <= 1'b0;
      baja_q   <= 1'b0;
    end else begin
      sync1_q  <= pulsado_c;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      armado_q <= armado_d;
      sube_q   <= sube_d;
      baja_q   <= baja_d;
    end
  end

  assign sube = sube_q;
  assign baja = baja_q;

endmodule

// File: rtl/botones_entrada.sv
// Button conditioner for the pet FSM: action pulses with priority, long-press test toggle,
// acelerar toggle. Optional auto-repeat of action pulses under BOTONES_REPEAT_EN.
module botones_entrada
  import botones_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 250000000,
  parameter int unsigned REPEAT_CYCLES     = 50000000,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_comer,
  input  logic btn_jugar,
  input  logic btn_descansar,
  input  logic btn_test,
  input  logic btn_acelerar,
  output logic comer,
  output logic jugar,
  output logic descansar,
  output logic test,
  output logic acelerar
);

  localparam int unsigned     HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIN = HOLD_W'(LONG_PRESS_CYCLES);

  logic [N_BTN-1:0]  raw_c;
  logic [N_BTN-1:0]  sube;
  logic [N_BTN-1:0]  baja;
  logic [N_ACC-1:0]  pide_c;
  estado_t           est_q [N_BTN];
  estado_t           est_d [N_BTN];
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              test_q, test_d;
  logic              acel_q, acel_d;
  logic [N_ACC-1:0]  acc_q, acc_d;

`ifdef BOTONES_REPEAT_EN
  localparam int unsigned    REP_W   = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_FIN = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q [N_ACC];
  logic [REP_W-1:0] rep_d [N_ACC];
`endif

  assign raw_c = {btn_acelerar, btn_test, btn_descansar, btn_jugar, btn_comer};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_antirrebote (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(raw_c[g]),
      .sube   (sube[g]),
      .baja   (baja[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      est_d[i] = est_q[i];
      if (est_q[i] == SUELTO) begin
        if (sube[i]) est_d[i] = PRESIONADO;
      end else if (baja[i]) begin
        est_d[i] = SUELTO;
      end
    end

    pide_c = sube[N_ACC-1:0];
`ifdef BOTONES_REPEAT_EN
    // Repeat timer restarts on every emitted pulse; a release in flight suppresses it.
    for (int i = 0; i < N_ACC; i++) begin
      rep_d[i] = '0;
      if (est_q[i] == PRESIONADO && !baja[i]) begin
        if (rep_q[i] == REP_FIN) begin
          pide_c[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + REP_W'(1);
        end
      end
    end
`endif
    // Keep only the lowest-index request.
    acc_d = pide_c & (~pide_c + N_ACC'(1));

    hold_d = hold_q;
    test_d = test_q;
    case (est_q[IDX_TEST])
      PRESIONADO: begin
        if (!baja[IDX_TEST]) begin
          hold_d = (hold_q == HOLD_FIN) ? hold_q : hold_q + HOLD_W'(1);
          if (hold_d == HOLD_FIN) begin
            test_d              = ~test_q;
            est_d[IDX_TEST]     = SOSTENIDO;
          end
        end
      end
      SOSTENIDO: hold_d = hold_q;
      default:   hold_d = '0;
    endcase

    acel_d = acel_q ^ sube[IDX_ACELERAR];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) est_q[i] <= SUELTO;
      hold_q <= '0;
      test_q <= 1'b0;
      acel_q <= 1'b0;
      acc_q  <= '0;
`ifdef BOTONES_REPEAT_EN
      for (int i = 0; i < N_ACC; i++) rep_q[i] <= '0;
`endif
    end else begin
      est_q  <= est_d;
      hold_q <= hold_d;
      test_q <= test_d;
      acel_q <= acel_d;
      acc_q  <= acc_d;
`ifdef BOTONES_REPEAT_EN
      rep_q  <= rep_d;
`endif
    end
  end

  assign comer     = acc_q[IDX_COMER];
  assign jugar     = acc_q[IDX_JUGAR];
  assign descansar = acc_q[IDX_DESCANSAR];
  assign test      = test_q;
  assign acelerar  = acel_q;

endmodule
